// File: rtl/uart_pkg.sv
// Shared constants and the arbiter state type for the UART transmit path.
package uart_pkg;
  localparam int CLK_PERIOD_NS = 10;
  localparam int BAUD_MULT     = 10416;
  localparam int BYTE_W        = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } arb_state_t;
endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Round-robin picker: first set bit of req at or after ptr, wrapping at NREQ.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IDXW = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [IDXW-1:0] idx,
  output logic            any
);
  int c;

  // Scan from the far end so the nearest candidate to ptr is written last.
  always_comb begin
    idx = ptr;
    any = 1'b0;
    c   = 0;
    for (int off = NREQ-1; off >= 0; off--) begin
      c = int'(ptr) + off;
      if (c >= NREQ) c = c - NREQ;
      if (req[c]) begin
        idx = IDXW'(c);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin, packet-locked arbiter in front of a single 8N1 UART transmitter,
// with supervision of the transmitter's busy flag and a start timeout.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int IDXW     = 1,
  parameter int START_TO = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*BYTE_W-1:0] req_data,
  input  logic [NREQ-1:0]        req_last,
  output logic [NREQ-1:0]        req_ready,
  output logic                   tx_start,
  output logic [BYTE_W-1:0]      tx_data,
  input  logic                   tx_busy,
  output logic [IDXW-1:0]        owner,
  output logic                   locked,
  output logic                   err
);
  localparam int CW = $clog2(START_TO + 1);

  arb_state_t      state, state_d;
  logic [IDXW-1:0] rr_ptr, pick_idx, nxt_owner;
  logic            pick_any, last_q;
  logic [CW-1:0]   to_cnt;
  logic            do_grant, do_load, do_abort, do_release;

  rr_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign nxt_owner = (int'(owner) == NREQ-1) ? '0 : owner + IDXW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d    = state;
    do_grant   = 1'b0;
    do_load    = 1'b0;
    do_abort   = 1'b0;
    do_release = 1'b0;
    case (state)
      IDLE: begin
        // A locked packet only ever continues with its owner.
        if (!tx_busy && (locked ? req_valid[owner] : pick_any)) begin
          do_grant = 1'b1;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        do_load = 1'b1;
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (tx_busy) state_d = WAIT_LO;
        else if (to_cnt == CW'(START_TO-1)) begin
          do_abort = 1'b1;
          state_d  = IDLE;
        end
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          do_release = last_q;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake strobes are registered so tx_start/req_ready rise together with
  // the freshly latched tx_data, two clocks after the request is seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready <= '0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
      owner     <= '0;
      locked    <= 1'b0;
      err       <= 1'b0;
      rr_ptr    <= '0;
      last_q    <= 1'b0;
      to_cnt    <= '0;
    end else begin
      req_ready <= '0;
      tx_start  <= 1'b0;
      err       <= 1'b0;
      if (do_grant && !locked) owner <= pick_idx;
      if (do_load) begin
        tx_data          <= req_data[owner*BYTE_W +: BYTE_W];
        last_q           <= req_last[owner];
        req_ready[owner] <= 1'b1;
        tx_start         <= 1'b1;
        locked           <= 1'b1;
        to_cnt           <= '0;
      end
      // Saturating: never wraps past START_TO even if the abort is missed.
      if (state == WAIT_HI && !tx_busy && to_cnt != CW'(START_TO))
        to_cnt <= to_cnt + CW'(1);
      if (do_abort || do_release) begin
        locked <= 1'b0;
        rr_ptr <= nxt_owner;
      end
      if (do_abort) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: directed timing sequences, a contention
// table, and randomized packet traffic against a packet-level round-robin model.
module tb_uart_tx_arb;
  localparam int NREQ = 3, IDXW = 2, START_TO = 16;

  logic                 clk = 1'b0, rst = 1'b1;
  logic [NREQ-1:0]      req_valid = '0, req_last = '0, req_ready;
  logic [NREQ*8-1:0]    req_data = '0;
  logic                 tx_start, tx_busy = 1'b0, locked, err;
  logic [7:0]           tx_data;
  logic [IDXW-1:0]      owner;

  uart_tx_arb #(.NREQ(NREQ), .IDXW(IDXW), .START_TO(START_TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_start(tx_start),
    .tx_data(tx_data), .tx_busy(tx_busy), .owner(owner), .locked(locked),
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] d; logic last; } ent_t;
  typedef struct { logic [7:0] d; int own; int cyc; } obs_t;
  typedef struct { logic [2:0] mask; logic [23:0] data; int n; logic [5:0] order; } vec_t;

  int vectors = 0, miscompares = 0, cyc = 0;
  ent_t rq[NREQ][$];
  ent_t mq[NREQ][$];
  obs_t log_q[$], exp_q[$];
  int   fall_q[$];
  logic [NREQ-1:0] hold = '0, stalled = '0;
  int   vld_cyc[NREQ];
  int   stall_pct = 0;
  int   tx_dly = 1, tx_len = 6, on_at = 0, off_at = 0;
  bit   tx_never = 0, busy_force = 0;
  int   err_cnt = 0, err_at = 0, lock_fall = 0, rdy0_cnt = 0;
  logic err_locked = 1'b0, prev_locked = 1'b0;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_log(input string nm, input int j, input logic [7:0] d, input int own);
    if (j >= log_q.size()) begin
      vectors++; miscompares++;
      $display("FAIL %s: byte %0d never sent, want 0x%0h from %0d", nm, j, d, own);
    end else chk(nm, {log_q[j].own[7:0], log_q[j].d}, {own[7:0], d});
  endtask

  // One clock: observe outputs, then update requester and transmitter models.
  task automatic tick();
    obs_t o;
    ent_t e;
    logic nb;
    @(negedge clk);
    cyc++;
    if (tx_start) begin
      o.d = tx_data; o.own = int'(owner); o.cyc = cyc;
      log_q.push_back(o);
      if (!tx_never) begin on_at = cyc + tx_dly; off_at = on_at + tx_len; end
    end
    if (err) begin err_cnt++; err_at = cyc; err_locked = locked; end
    if (prev_locked && !locked) lock_fall = cyc;
    prev_locked = locked;
    if (tx_start || req_ready != '0)
      chk("ready_vs_start", {29'd0, req_ready}, tx_start ? (32'd1 << owner) : 32'd0);
    if (req_ready[0]) rdy0_cnt++;
    for (int i = 0; i < NREQ; i++)
      if (req_ready[i] && hold[i]) begin
        e = rq[i].pop_front();
        hold[i] = 1'b0;
        stalled[i] = !e.last && ($urandom_range(99) < stall_pct);
      end
    for (int i = 0; i < NREQ; i++) begin
      if (!hold[i] && rq[i].size() > 0 && (!stalled[i] || $urandom_range(3) == 0)) begin
        hold[i] = 1'b1; stalled[i] = 1'b0; vld_cyc[i] = cyc;
      end
      req_valid[i] = hold[i];
      if (hold[i]) begin
        req_data[i*8 +: 8] = rq[i][0].d;
        req_last[i] = rq[i][0].last;
      end else begin
        req_data[i*8 +: 8] = 8'h00;
        req_last[i] = 1'b0;
      end
    end
    nb = busy_force || (cyc >= on_at && cyc < off_at);
    if (tx_busy && !nb) fall_q.push_back(cyc);
    tx_busy = nb;
  endtask

  task automatic drain(input int maxc);
    int n;
    bit empty;
    n = 0;
    do begin
      tick(); n++;
      empty = 1;
      for (int i = 0; i < NREQ; i++) if (rq[i].size() != 0) empty = 0;
    end while (n < maxc && !(empty && !tx_busy && !locked));
    if (n >= maxc) begin
      vectors++; miscompares++;
      $display("FAIL drain: still busy after %0d cycles, want idle", n);
    end
  endtask

  task automatic push(input int i, input logic [7:0] d, input logic last);
    ent_t e;
    e.d = d; e.last = last;
    rq[i].push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1);
  end

  initial begin
    // Contention table: one single-byte packet per masked requester, expected
    // owner order (2 bits each, first in the low bits) from the running rr_ptr.
    tbl[0] = '{3'b011, 24'hC0B0A0, 2, 6'b000001};
    tbl[1] = '{3'b111, 24'hC1B1A1, 3, 6'b001001};
    tbl[2] = '{3'b101, 24'hC2B2A2, 2, 6'b000010};
    tbl[3] = '{3'b100, 24'hC3B3A3, 1, 6'b000010};
    tbl[4] = '{3'b110, 24'hC4B4A4, 2, 6'b001001};
    tbl[5] = '{3'b111, 24'hC5B5A5, 3, 6'b100100};
    tbl[6] = '{3'b001, 24'hC6B6A6, 1, 6'b000000};
    tbl[7] = '{3'b110, 24'hC7B7A7, 2, 6'b001001};

    tick(); tick();
    chk("rst_req_ready", {29'd0, req_ready}, 0);
    chk("rst_tx_start", {31'd0, tx_start}, 0);
    chk("rst_tx_data", {24'd0, tx_data}, 0);
    chk("rst_owner", {30'd0, owner}, 0);
    chk("rst_locked", {31'd0, locked}, 0);
    chk("rst_err", {31'd0, err}, 0);
    rst = 1'b0;

    // Single byte from requester 0.
    tx_dly = 1; tx_len = 6; rdy0_cnt = 0; fall_q.delete(); log_q.delete();
    push(0, 8'h45, 1'b1);
    drain(200);
    chk("single_count", log_q.size(), 1);
    chk_log("single_byte", 0, 8'h45, 0);
    if (log_q.size() > 0) chk("single_latency", log_q[0].cyc - vld_cyc[0], 2);
    chk("single_ready_width", rdy0_cnt, 1);
    if (fall_q.size() > 0) chk("single_lock_fall", lock_fall - fall_q[0], 1);

    // Table run; rr_ptr now 1, so requester 1 wins the first vector.
    for (int v = 0; v < 8; v++) begin
      logic [5:0]  ord;
      logic [23:0] dat;
      int          own;
      ord = tbl[v].order; dat = tbl[v].data;
      log_q.delete();
      for (int i = 0; i < NREQ; i++) if (tbl[v].mask[i]) push(i, dat[i*8 +: 8], 1'b1);
      drain(300);
      chk("tbl_count", log_q.size(), tbl[v].n);
      for (int j = 0; j < tbl[v].n; j++) begin
        own = int'(ord[2*j +: 2]);
        chk_log("tbl_order", j, dat[own*8 +: 8], own);
      end
    end

    // Simultaneous requests from a fresh rr_ptr = 0.
    do_reset();
    log_q.delete();
    push(0, 8'h41, 1'b1); push(1, 8'h42, 1'b1);
    drain(300);
    chk("cont_count", log_q.size(), 2);
    chk_log("cont_first", 0, 8'h41, 0);
    chk_log("cont_second", 1, 8'h42, 1);

    // Packet lock with an owner that pauses between its bytes.
    stall_pct = 100; log_q.delete();
    push(0, 8'h10, 1'b0); push(0, 8'h11, 1'b0); push(0, 8'h12, 1'b1);
    push(1, 8'h99, 1'b1);
    drain(500);
    stall_pct = 0;
    chk("lock_count", log_q.size(), 4);
    chk_log("lock_b0", 0, 8'h10, 0);
    chk_log("lock_b1", 1, 8'h11, 0);
    chk_log("lock_b2", 2, 8'h12, 0);
    chk_log("lock_b3", 3, 8'h99, 1);

    // Start timeout: busy never rises.
    tx_never = 1; err_cnt = 0; log_q.delete();
    push(0, 8'h33, 1'b1);
    drain(100);
    tx_never = 0;
    chk("to_err_count", err_cnt, 1);
    if (log_q.size() > 0) chk("to_err_delay", err_at - log_q[0].cyc, START_TO);
    chk("to_locked_at_err", {31'd0, err_locked}, 0);
    log_q.delete();
    push(0, 8'h34, 1'b1); push(1, 8'h35, 1'b1);
    drain(300);
    chk_log("to_after_first", 0, 8'h35, 1);
    chk_log("to_after_second", 1, 8'h34, 0);

    // Back-to-back single-byte packets from one requester.
    tx_dly = 1; tx_len = 5; fall_q.delete(); log_q.delete();
    push(0, 8'h01, 1'b1); push(0, 8'h02, 1'b1);
    drain(300);
    chk_log("b2b_first", 0, 8'h01, 0);
    chk_log("b2b_second", 1, 8'h02, 0);
    // Busy low is first seen by the WAIT_LO exit edge; one IDLE and one LOAD clock follow.
    if (log_q.size() > 1 && fall_q.size() > 0) chk("b2b_gap", log_q[1].cyc - fall_q[0], 3);

    // Transmitter still busy while a request waits in IDLE.
    busy_force = 1; tick();
    log_q.delete(); fall_q.delete();
    push(1, 8'hC3, 1'b1);
    repeat (6) tick();
    chk("idle_busy_hold", log_q.size(), 0);
    busy_force = 0;
    drain(200);
    chk_log("idle_busy_byte", 0, 8'hC3, 1);
    if (log_q.size() > 0 && fall_q.size() > 0) chk("idle_busy_latency", log_q[0].cyc - fall_q[0], 2);

    // Reset while the transmitter is mid-byte.
    tx_dly = 1; tx_len = 20; log_q.delete();
    push(0, 8'h66, 1'b1);
    for (int n = 0; n < 20 && !tx_busy; n++) tick();
    tick(); tick();
    chk("rst_mid_locked", {31'd0, locked}, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_outputs", {16'd0, req_ready, tx_start, tx_data, owner, locked, err}, 0);
    tick();
    rst = 1'b0;
    drain(100);
    tx_len = 6; log_q.delete();
    push(0, 8'h5A, 1'b1);
    drain(200);
    chk("rst_after_count", log_q.size(), 1);
    chk_log("rst_after_byte", 0, 8'h5A, 0);
    if (log_q.size() > 0) chk("rst_after_latency", log_q[0].cyc - vld_cyc[0], 2);

    // Random packet traffic against a packet-level round-robin reference.
    do_reset();
    stall_pct = 50; err_cnt = 0;
    begin
      int mptr, found, np, len;
      bit more;
      ent_t e;
      obs_t o;
      mptr = 0;
      for (int r = 0; r < 6; r++) begin
        tx_dly = $urandom_range(3); tx_len = $urandom_range(8, 1);
        exp_q.delete(); log_q.delete();
        for (int i = 0; i < NREQ; i++) begin
          np = $urandom_range(3);
          for (int p = 0; p < np; p++) begin
            len = $urandom_range(4, 1);
            for (int b = 0; b < len; b++) begin
              e.d = 8'($urandom); e.last = (b == len-1);
              rq[i].push_back(e); mq[i].push_back(e);
            end
          end
        end
        more = 1;
        while (more) begin
          found = -1;
          for (int off = 0; off < NREQ; off++)
            if (found < 0 && mq[(mptr + off) % NREQ].size() > 0) found = (mptr + off) % NREQ;
          if (found < 0) more = 0;
          else begin
            do begin
              e = mq[found].pop_front();
              o.d = e.d; o.own = found; o.cyc = 0;
              exp_q.push_back(o);
            end while (!e.last);
            mptr = (found + 1) % NREQ;
          end
        end
        drain(4000);
        chk("rnd_count", log_q.size(), exp_q.size());
        for (int j = 0; j < exp_q.size(); j++) chk_log("rnd_byte", j, exp_q[j].d, exp_q[j].own);
      end
    end
    chk("rnd_no_err", err_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
